// File: rtl/sample_mem_arbiter_if.sv
// Processor-side and RAM-side buses of the sample memory arbiter.
// The slave view is taken by the arbiter; the master view by the CPU/RAM environment.
interface sample_mem_arbiter_if;
   logic        cpu_mem_req;
   logic        cpu_we;
   logic [31:0] cpu_addr;
   logic [31:0] cpu_wdata;
   logic [31:0] cpu_rdata;
   logic        cpu_stall;
   logic        mem_we;
   logic [31:0] mem_addr;
   logic [31:0] mem_wdata;
   logic [31:0] mem_rdata;

   modport slave (
      input  cpu_mem_req, cpu_we, cpu_addr, cpu_wdata, mem_rdata,
      output cpu_rdata, cpu_stall, mem_we, mem_addr, mem_wdata
   );

   modport master (
      output cpu_mem_req, cpu_we, cpu_addr, cpu_wdata, mem_rdata,
      input  cpu_rdata, cpu_stall, mem_we, mem_addr, mem_wdata
   );
endinterface

// File: rtl/sample_mem_arbiter.sv
// Shares the data-RAM port between the CPU Memory stage and an audio sample reader,
// stealing idle cycles and freezing the pipeline for one cycle when the CPU hogs the port.
module sample_mem_arbiter #(
   parameter int          SAMPLE_DIV = 1134,
   parameter int          MAX_WAIT   = 4,
   parameter int          BUF_LEN    = 1024,
   parameter logic [31:0] BASE0      = 32'd0,
   parameter logic [31:0] BASE1      = 32'd1024
) (
   input  logic                       clk,
   input  logic                       rst,
   input  logic                       SongSelector,
   input  logic                       play_en,
   sample_mem_arbiter_if.slave        bus,
   output logic [31:0]                sample_out,
   output logic                       sample_valid
);

   localparam int TW = $clog2(SAMPLE_DIV);
   localparam int WW = $clog2(MAX_WAIT + 1);
   localparam int PW = $clog2(BUF_LEN);
   localparam logic [TW-1:0] TLAST = TW'(SAMPLE_DIV - 1);
   localparam logic [WW-1:0] WLAST = WW'(MAX_WAIT - 1);
   localparam logic [PW-1:0] PLAST = PW'(BUF_LEN - 1);

   typedef enum logic [1:0] {IDLE, PENDING, FORCE} state_t;

   state_t          state, state_nxt;
   logic [TW-1:0]   tcnt;
   logic [WW-1:0]   wcnt;
   logic [PW-1:0]   rd_ptr;
   logic [31:0]     base;
   logic            song_q;
   logic            tick;
   logic            grant;
   logic            song_switch;

   function automatic logic [PW-1:0] ptr_next(input logic [PW-1:0] p);
      return (p == PLAST) ? '0 : p + PW'(1);
   endfunction

   assign song_switch = (SongSelector != song_q);
   assign tick        = play_en && (tcnt == TLAST);
   assign grant       = ((state == PENDING) && !bus.cpu_mem_req) || (state == FORCE);

   always_ff @(posedge clk) begin
      if (rst) state <= IDLE;
      else     state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      case (state)
         IDLE:    if (tick) state_nxt = PENDING;
         PENDING: begin
            if (!bus.cpu_mem_req)     state_nxt = IDLE;
            else if (wcnt == WLAST)   state_nxt = FORCE;
         end
         FORCE:   state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
      // A song change abandons whatever request is in flight.
      if (song_switch) state_nxt = IDLE;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         tcnt         <= '0;
         wcnt         <= '0;
         rd_ptr       <= '0;
         song_q       <= SongSelector;
         base         <= SongSelector ? BASE1 : BASE0;
         sample_out   <= '0;
         sample_valid <= 1'b0;
      end else begin
         song_q       <= SongSelector;
         sample_valid <= 1'b0;
         if (song_switch) begin
            base   <= SongSelector ? BASE1 : BASE0;
            rd_ptr <= '0;
            tcnt   <= '0;
         end else begin
            if (!play_en || tcnt == TLAST) tcnt <= '0;
            else                           tcnt <= tcnt + TW'(1);
            if (grant) begin
               sample_out   <= bus.mem_rdata;
               sample_valid <= 1'b1;
               rd_ptr       <= ptr_next(rd_ptr);
            end
         end
         // Holding wcnt at zero outside PENDING makes every entry start from zero.
         if (state != PENDING)     wcnt <= '0;
         else if (bus.cpu_mem_req) wcnt <= wcnt + WW'(1);
      end
   end

   assign bus.cpu_stall = (state == FORCE);
   assign bus.cpu_rdata = bus.mem_rdata;
   assign bus.mem_we    = grant ? 1'b0 : bus.cpu_we;
   assign bus.mem_addr  = grant ? (base + 32'(rd_ptr)) : bus.cpu_addr;
   assign bus.mem_wdata = bus.cpu_wdata;

endmodule

// File: tb/tb_sample_mem_arbiter.sv
// Bench for sample_mem_arbiter: directed scenarios plus random traffic,
// all checked against a request-level reference model with its own RAM image.
module tb_sample_mem_arbiter;
   localparam int          SAMPLE_DIV = 8;
   localparam int          MAX_WAIT   = 3;
   localparam int          BUF_LEN    = 4;
   localparam logic [31:0] BASE0      = 32'd0;
   localparam logic [31:0] BASE1      = 32'd16;

   logic        clk = 1'b0;
   logic        rst;
   logic        SongSelector;
   logic        play_en;
   logic [31:0] sample_out;
   logic        sample_valid;

   sample_mem_arbiter_if bus ();

   sample_mem_arbiter #(
      .SAMPLE_DIV(SAMPLE_DIV), .MAX_WAIT(MAX_WAIT), .BUF_LEN(BUF_LEN),
      .BASE0(BASE0), .BASE1(BASE1)
   ) dut (
      .clk(clk), .rst(rst), .SongSelector(SongSelector), .play_en(play_en),
      .bus(bus), .sample_out(sample_out), .sample_valid(sample_valid)
   );

   always #5 clk = ~clk;

   logic [31:0] ram [64];
   assign bus.mem_rdata = ram[bus.mem_addr[5:0]];
   always @(posedge clk) if (bus.mem_we) ram[bus.mem_addr[5:0]] <= bus.mem_wdata;

   // reference model state
   logic [31:0] ref_mem [64];
   int          m_cnt, m_busy, m_ptr;
   bit          m_req, m_force, m_sv, m_song;
   logic [31:0] m_so;

   int          n_vec = 0;
   int          n_err = 0;
   bit          collect = 0;
   logic [31:0] so_q [$];
   bit          obs_sv, obs_stall, obs_we;
   logic [31:0] obs_so, obs_addr, obs_wdata, obs_rdata;

   task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_vec++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, got, exp, $time);
      end
   endtask

   task automatic model_reset();
      m_cnt = 0; m_busy = 0; m_ptr = 0;
      m_req = 0; m_force = 0; m_sv = 0; m_so = '0;
      m_song = SongSelector;
   endtask

   // One clock: check outputs mid-cycle, advance the model over the edge.
   task automatic step();
      bit          grant, ewe;
      int          base;
      logic [31:0] eaddr;
      base  = m_song ? int'(BASE1) : int'(BASE0);
      grant = m_force || (m_req && !bus.cpu_mem_req);
      eaddr = grant ? 32'(base + m_ptr) : bus.cpu_addr;
      ewe   = grant ? 1'b0 : bus.cpu_we;
      #4;
      obs_sv = sample_valid; obs_so = sample_out; obs_stall = bus.cpu_stall;
      obs_we = bus.mem_we; obs_addr = bus.mem_addr; obs_wdata = bus.mem_wdata;
      obs_rdata = bus.cpu_rdata;
      check_val("sample_valid", 32'(sample_valid), 32'(m_sv));
      check_val("sample_out", sample_out, m_so);
      check_val("cpu_stall", 32'(bus.cpu_stall), 32'(m_force));
      check_val("mem_we", 32'(bus.mem_we), 32'(ewe));
      check_val("mem_addr", bus.mem_addr, eaddr);
      check_val("mem_wdata", bus.mem_wdata, bus.cpu_wdata);
      check_val("cpu_rdata", bus.cpu_rdata, ref_mem[eaddr[5:0]]);
      if (collect && obs_sv) so_q.push_back(obs_so);
      if (ewe) ref_mem[eaddr[5:0]] = bus.cpu_wdata;
      if (rst) model_reset();
      else if (SongSelector != m_song) begin
         m_song = SongSelector; m_ptr = 0; m_cnt = 0;
         m_req = 0; m_force = 0; m_sv = 0;
      end else begin
         m_sv = grant;
         if (grant) begin
            m_so  = ref_mem[(base + m_ptr) % 64];
            m_ptr = (m_ptr + 1) % BUF_LEN;
         end
         if (m_force) m_force = 0;
         else if (m_req) begin
            if (!bus.cpu_mem_req) m_req = 0;
            else begin
               m_busy++;
               if (m_busy == MAX_WAIT) begin m_req = 0; m_force = 1; end
            end
         end else if (play_en && m_cnt == SAMPLE_DIV - 1) begin
            m_req = 1; m_busy = 0;
         end
         m_cnt = play_en ? (m_cnt + 1) % SAMPLE_DIV : 0;
      end
      @(posedge clk); #1;
   endtask

   // Runs until the tick edge has passed; returns at the start of cycle tick+1.
   task automatic wait_tick();
      int n = 0;
      while (!(play_en && m_cnt == SAMPLE_DIV - 1 && !m_req && !m_force) && n < 40) begin
         step();
         n++;
      end
      check_val("tick_align", 32'(n < 40), 32'd1);
      step();
   endtask

   task automatic idle_bus();
      bus.cpu_mem_req = 0; bus.cpu_we = 0; bus.cpu_addr = 32'd40; bus.cpu_wdata = 32'd0;
   endtask

   initial begin
      bit          sv_h [1:6];
      bit          st_h [1:6];
      bit          we_h [1:6];
      int          exp_seq [5];
      exp_seq = '{100, 101, 102, 103, 100};
      for (int i = 0; i < 64; i++) begin
         ram[i] = 32'(i + 100);
         ref_mem[i] = 32'(i + 100);
      end
      rst = 1; SongSelector = 0; play_en = 0;
      idle_bus();
      @(posedge clk); #1;
      model_reset();
      step();
      rst = 0;

      // idle processor, continuous playback
      play_en = 1; collect = 1; so_q.delete();
      for (int i = 0; i < 48; i++) begin
         step();
         check_val("idle_no_stall", 32'(obs_stall), 32'd0);
      end
      collect = 0;
      check_val("idle_nsamples", 32'(so_q.size() >= 5), 32'd1);
      for (int i = 0; i < 5 && i < so_q.size(); i++) check_val("idle_seq", so_q[i], 32'(exp_seq[i]));

      // two busy cycles then idle
      wait_tick();
      for (int k = 1; k <= 6; k++) begin
         bus.cpu_mem_req = (k <= 2);
         step();
         sv_h[k] = obs_sv; st_h[k] = obs_stall;
      end
      check_val("busy2_valid_t3", 32'(sv_h[3]), 32'd0);
      check_val("busy2_valid_t4", 32'(sv_h[4]), 32'd1);
      check_val("busy2_no_stall", 32'(st_h[1] | st_h[2] | st_h[3] | st_h[4]), 32'd0);

      // permanently busy writer
      idle_bus();
      wait_tick();
      bus.cpu_mem_req = 1; bus.cpu_we = 1; bus.cpu_addr = 32'd40;
      for (int k = 1; k <= 6; k++) begin
         bus.cpu_wdata = $urandom;
         step();
         sv_h[k] = obs_sv; st_h[k] = obs_stall; we_h[k] = obs_we;
      end
      check_val("force_stall_t3", 32'(st_h[3]), 32'd0);
      check_val("force_stall_t4", 32'(st_h[4]), 32'd1);
      check_val("force_stall_t5", 32'(st_h[5]), 32'd0);
      check_val("force_valid_t5", 32'(sv_h[5]), 32'd1);
      check_val("force_we_t3", 32'(we_h[3]), 32'd1);
      check_val("force_we_t4", 32'(we_h[4]), 32'd0);
      idle_bus();

      // processor write then read-back
      play_en = 0;
      step(); step();
      bus.cpu_mem_req = 1; bus.cpu_we = 1; bus.cpu_addr = 32'd5; bus.cpu_wdata = 32'd7;
      step();
      check_val("wr_we", 32'(obs_we), 32'd1);
      check_val("wr_addr", obs_addr, 32'd5);
      check_val("wr_data", obs_wdata, 32'd7);
      bus.cpu_we = 0; bus.cpu_wdata = 32'd0;
      step();
      check_val("rd_back", obs_rdata, 32'd7);
      idle_bus();

      // song switch while a request is pending
      play_en = 1;
      wait_tick();
      bus.cpu_mem_req = 1; SongSelector = 1;
      step();
      bus.cpu_mem_req = 0; collect = 1; so_q.delete();
      step();
      check_val("switch_no_valid", 32'(obs_sv), 32'd0);
      for (int i = 0; i < 24; i++) step();
      collect = 0;
      check_val("switch_nsamples", 32'(so_q.size() >= 2), 32'd1);
      if (so_q.size() >= 2) begin
         check_val("switch_s0", so_q[0], 32'd116);
         check_val("switch_s1", so_q[1], 32'd117);
      end

      // reset in the forced cycle
      wait_tick();
      bus.cpu_mem_req = 1;
      for (int k = 1; k <= 3; k++) step();
      rst = 1; SongSelector = 0;
      step();
      check_val("rstf_stall_before", 32'(obs_stall), 32'd1);
      rst = 0; bus.cpu_mem_req = 0; collect = 1; so_q.delete();
      step();
      check_val("rstf_stall", 32'(obs_stall), 32'd0);
      check_val("rstf_valid", 32'(obs_sv), 32'd0);
      check_val("rstf_out", obs_so, 32'd0);
      for (int i = 0; i < 16; i++) step();
      collect = 0;
      check_val("rstf_nsamples", 32'(so_q.size() >= 1), 32'd1);
      if (so_q.size() >= 1) check_val("rstf_first", so_q[0], 32'd100);

      // random traffic
      for (int i = 0; i < 600; i++) begin
         bus.cpu_mem_req = ($urandom_range(0, 1) == 1);
         bus.cpu_we      = bus.cpu_mem_req && ($urandom_range(0, 2) == 0);
         bus.cpu_addr    = 32'($urandom_range(0, 63));
         bus.cpu_wdata   = $urandom;
         play_en         = ($urandom_range(0, 9) != 0);
         if ($urandom_range(0, 39) == 0) SongSelector = ~SongSelector;
         rst             = ($urandom_range(0, 99) == 0);
         step();
      end

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end
endmodule
